// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub
//
// Serial add/subtract unit. Computes A+B or A-B over WIDTH bits, four bits
// per clock, least-significant nibble first. Each nibble slice adds
// a + (b ^ {4{sub}}) + carry. The carry chain is seeded with sub, so
// subtraction is two's complement. The final flag is sub ^ carry-out: a
// carry for an add, a borrow for a subtract.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_in_valid   operands presented on i_a / i_b / i_sub
//   o_in_ready   unit idle and able to accept operands
//   i_a, i_b     WIDTH-bit operands
//   i_sub        1 = A-B, 0 = A+B
//   o_out_valid  result on o_s / o_cout is valid
//   i_out_ready  consumer accepts the result
//   o_s          sum or difference modulo 2^WIDTH
//   o_cout       add: unsigned carry-out; subtract: borrow (A < B)

module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_inReady;
  logic             r_outValid;

  logic [3:0]       w_aNib;
  logic [3:0]       w_bNib;
  logic [4:0]       w_sum;

  // Select the nibble pair addressed by the counter. Constant-index slices
  // keep the mux plain for every legal WIDTH.
  always_comb begin
    w_aNib = '0;
    w_bNib = '0;
    for (int k = 0; k < NIB; k++) begin
      if (r_cnt == CW'(k)) begin
        w_aNib = r_a[4*k +: 4];
        w_bNib = r_b[4*k +: 4];
      end
    end
  end

  // One 4-bit add/sub slice. Bit 4 is the slice carry-out.
  assign w_sum = {1'b0, w_aNib} + {1'b0, w_bNib ^ {4{r_sub}}} + {4'b0000, r_carry};

  // Control FSM and datapath registers. Every output is registered here, so
  // the handshake flags change only on clock edges. In IDLE the operands are
  // latched. In RUN one nibble is produced per cycle. DONE holds the result
  // until the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_s        <= '0;
      r_cout     <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_sub     <= i_sub;
            r_carry   <= i_sub;
            r_cnt     <= '0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NIB; k++) begin
            if (r_cnt == CW'(k)) begin
              r_s[4*k +: 4] <= w_sum[3:0];
            end
          end
          r_carry <= w_sum[4];
          if (r_cnt == CW'(NIB - 1)) begin
            r_cout     <= r_sub ^ w_sum[4];
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_inReady;
  assign o_out_valid = r_outValid;
  assign o_s         = r_s;
  assign o_cout      = r_cout;

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Sequential add/subtract unit for the 16-bit fixed-point datapath. It processes a WIDTH-bit add or subtract one 4-bit nibble per clock, LSB nibble first, using the same add/sub slice semantics as the combinational 4-bit stage:
- b is XORed with sub.
- The first carry-in equals sub.
- The final flag is sub XOR carry-out.

It sits between the partial-product generator and the multiplier's final accumulation. It trades latency for area and exposes a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, default 16: operand width; must be a multiple of 4 and at least 4.
- NIB, default WIDTH/4 (derived, not overridable): number of nibble cycles per operation.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand presented.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  operation select: 1 = A−B, 0 = A+B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  flag: add → unsigned carry-out; subtract → borrow (1 when A < B unsigned).

## Operation
FSM states:
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, capture a, b and sub; set carry register = sub, nibble counter = 0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle computes nibble k = counter:
    - {c, r} = a[4k+3:4k] + (b[4k+3:4k] ^ {4{sub}}) + carry.
    - r is written into s[4k+3:4k]; carry ← c.
  - When counter = NIB−1, set cout ← sub ^ c and go to DONE; otherwise the counter increments.
- DONE:
  - out_valid=1, in_ready=0.
  - s and cout are held stable.
  - On out_ready, go to IDLE.

Arithmetic rules:
- Subtraction is two's complement (A + ~B + 1). s wraps modulo 2^WIDTH.
- No signed-overflow detection. Callers interpret s as signed Q-format if required.

Handshake rules:
- A transfer occurs on a clock edge where valid and ready are both 1.
- in_valid while in_ready=0 is ignored; operands are not queued.
- a, b and sub are only sampled on the accepting edge. Later changes do not affect the running operation.
- out_valid, once asserted, stays high until the out_ready edge.

## Timing
Reset:
- While rst_n=0 at a rising edge: state ← IDLE, counter ← 0, carry ← 0, s ← 0, cout ← 0.
- out_valid=0 and in_ready=1 after reset release.
- Reset mid-RUN or mid-DONE aborts the operation and discards the result. No out_valid pulse follows.

Latency and throughput:
- Accepting edge E. RUN occupies edges E+1 … E+NIB. out_valid is high from edge E+NIB (the 4th edge for WIDTH=16).
- With out_ready held 1: DONE lasts one cycle and IDLE follows at E+NIB+1. The next operand can be accepted at edge E+NIB+2.
- Peak throughput is therefore one operation per NIB+2 cycles (6 for WIDTH=16).
- in_ready is asserted only in IDLE, so no same-cycle accept-on-drain.

Outputs:
- All outputs are registered.
- The s bits of not-yet-processed nibbles may change during RUN. They are only valid while out_valid=1.

## Test plan
- Add 0x1234 + 0x0FFF, sub=0 → out_valid 4 edges after accept; s=0x2233, cout=0.
- Add 0xFFFF + 0x0001, sub=0 → s=0x0000, cout=1 (carry ripples through all four nibble cycles).
- Subtract 0x0005 − 0x0007, sub=1 → s=0xFFFE, cout=1.
- Subtract 0x8000 − 0x8000 → s=0x0000, cout=0.
- Subtract 0x1000 − 0x0001 → s=0x0FFF, cout=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid; s and cout must stay constant and in_ready must stay 0.
  - Toggle in_valid with new operands during RUN; the result must be unaffected.
  - Raise out_ready; in_ready returns 1 on the next cycle.
- Reset mid-operation: accept 0x1234 + 0x1111, then assert rst_n=0 on the 2nd RUN edge.
  - Expect out_valid=0, in_ready=1, s=0, cout=0 after that edge.
  - A subsequent 0x0001 + 0x0001 completes with s=0x0002, cout=0.
